// File: rtl/j_serializer.sv
// j_serializer: parallel-to-serial front end driving the single-bit `j`
// stream for the downstream sequence detector.
//
// A WIDTH-bit word is accepted over a load/ready handshake, shifted out MSB
// first with each bit held DIV clocks, then followed by GAP idle bit-times.
// The line idles at 1 so the detector stays in its start state.
//
// Ports:
//   clk   - system clock, rising-edge active
//   rst   - asynchronous reset, active-low
//   load  - word valid; taken on a rising edge while ready=1
//   din   - parallel word, sampled only on acceptance
//   ready - 1 only in IDLE
//   busy  - 1 while shifting or in the idle gap
//   j     - registered serial data, 1 when idle
//   done  - one-cycle pulse on the first cycle after the last data bit
module j_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             j,
  output logic             done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  // With GAP=0 the gap state is never entered; the value only needs to be legal.
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             j_reg;
  logic             done_reg;

  // ready/busy are pure decodes of the state register.
  assign ready = (state_reg == S_IDLE);
  assign busy  = (state_reg == S_SHIFT) || (state_reg == S_GAP);
  assign j     = j_reg;
  assign done  = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      j_reg       <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          j_reg <= 1'b1;
          if (load) begin
            shift_reg   <= din;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            // MSB goes on the line on the accepting edge itself.
            j_reg       <= din[WIDTH-1];
            state_reg   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg <= '0;
              j_reg       <= 1'b1;
              done_reg    <= 1'b1;
              state_reg   <= (GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
              // Next bit is the one about to become the MSB after the shift.
              j_reg       <= shift_reg[WIDTH-2];
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end

        S_GAP: begin
          j_reg <= 1'b1;
          // Gap is measured in bit-times: DIV clocks per gap bit.
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (gap_cnt_reg == GAP_LAST) begin
              gap_cnt_reg <= '0;
              state_reg   <= S_IDLE;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end

        default: begin
          state_reg <= S_IDLE;
          j_reg     <= 1'b1;
        end
      endcase
    end
  end

endmodule
